// File: rtl/cwalk_pkg.sv
// rtl/cwalk_pkg.sv - crosswalk sequencer states and per-state lamp decode
// Ports: none (package). Provides state_t, lamps_t, the per-state lamp
// constants and lamps_for(), which maps a state to its head outputs.
package cwalk_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_GREEN    = 3'd1,
        ST_YELLOW   = 3'd2,
        ST_ALL_RED  = 3'd3,
        ST_WALK     = 3'd4,
        ST_FLASH    = 3'd5
    } state_t;

    typedef struct packed {
        logic car_g;
        logic car_y;
        logic car_r;
        logic walk;
        logic hand;
        logic num_on;
    } lamps_t;

    localparam lamps_t LAMPS_GREEN  = 6'b100_010;
    localparam lamps_t LAMPS_YELLOW = 6'b010_010;
    localparam lamps_t LAMPS_RED    = 6'b001_010;
    localparam lamps_t LAMPS_WALK   = 6'b001_100;
    localparam lamps_t LAMPS_FLASH  = 6'b001_011;

    function automatic lamps_t lamps_for(input state_t s);
        case (s)
            ST_GREEN:  return LAMPS_GREEN;
            ST_YELLOW: return LAMPS_YELLOW;
            ST_WALK:   return LAMPS_WALK;
            ST_FLASH:  return LAMPS_FLASH;
            default:   return LAMPS_RED;
        endcase
    endfunction

endpackage

// File: rtl/cwalk_ctrl_if.sv
// rtl/cwalk_ctrl_if.sv - pedestrian request and signal-head bundle
// Signals: ped_req (button), car_g/car_y/car_r (vehicle head),
// walk/hand/num_on/num (crosswalk head), ped_wait (request lamp).
// master: the sequencer (drives heads, reads ped_req).
// slave:  the button/display side (drives ped_req, reads heads).
interface cwalk_ctrl_if;
    logic       ped_req;
    logic       car_g;
    logic       car_y;
    logic       car_r;
    logic       walk;
    logic       hand;
    logic       num_on;
    logic [3:0] num;
    logic       ped_wait;

    modport master (
        input  ped_req,
        output car_g, car_y, car_r, walk, hand, num_on, num, ped_wait
    );

    modport slave (
        output ped_req,
        input  car_g, car_y, car_r, walk, hand, num_on, num, ped_wait
    );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
// Ports: clk, reset (async, active-low), tick (high while count = TICK_DIV-1).
module tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/cwalk_ctrl.sv
// rtl/cwalk_ctrl.sv - mid-block pedestrian crossing sequencer
// Ports: clk, reset (async, active-low), bus (cwalk_ctrl_if.master):
// ped_req in; car_g/car_y/car_r, walk/hand, num_on/num, ped_wait out.
// Holds the FSM, per-state tick timer, pending-request latch and the
// registered head outputs.
module cwalk_ctrl
    import cwalk_pkg::*;
#(
    parameter int TICK_DIV  = 50,
    parameter int GREEN_MIN = 8,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5,
    parameter int CNTDN_T   = 9
) (
    input  logic          clk,
    input  logic          reset,
    cwalk_ctrl_if.master  bus
);
    // Timer values on the last tick of each state (timer counts from 0).
    localparam logic [3:0] GREEN_LAST  = 4'(GREEN_MIN - 1);
    localparam logic [3:0] GREEN_SAT   = 4'(GREEN_MIN);
    localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_T - 1);
    localparam logic [3:0] ALLRED_LAST = 4'(ALLRED_T - 1);
    localparam logic [3:0] WALK_LAST   = 4'(WALK_T - 1);
    localparam logic [3:0] CNTDN_LAST  = 4'(CNTDN_T - 1);
    localparam logic [3:0] CNTDN_TOP   = 4'(CNTDN_T);

    logic       tick;
    state_t     state, state_nx;
    logic [3:0] timer, timer_nx;
    logic       pend, pend_nx;
    logic       done;
    lamps_t     lamps_q, lamps_nx;
    logic [3:0] num_q, num_nx;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // State register, tick timer, pending latch and head registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            timer   <= '0;
            pend    <= 1'b0;
            lamps_q <= LAMPS_RED;
            num_q   <= '0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pend    <= pend_nx;
            lamps_q <= lamps_nx;
            num_q   <= num_nx;
        end
    end

    // Next state. done means "this tick completes the state".
    always_comb begin
        done     = 1'b0;
        state_nx = state;
        timer_nx = timer;
        case (state)
            ST_CLEAR:   done = (timer == ALLRED_LAST);
            // Green timer saturates at GREEN_MIN, so >= GREEN_MIN-1 covers
            // both "reaching the minimum on this tick" and "already past it".
            ST_GREEN:   done = (timer >= GREEN_LAST) && (pend || bus.ped_req);
            ST_YELLOW:  done = (timer == YELLOW_LAST);
            ST_ALL_RED: done = (timer == ALLRED_LAST);
            ST_WALK:    done = (timer == WALK_LAST);
            ST_FLASH:   done = (timer == CNTDN_LAST);
            default:    done = 1'b1;
        endcase
        if (tick) begin
            if (done) begin
                timer_nx = '0;
                case (state)
                    ST_CLEAR:   state_nx = ST_GREEN;
                    ST_GREEN:   state_nx = ST_YELLOW;
                    ST_YELLOW:  state_nx = ST_ALL_RED;
                    ST_ALL_RED: state_nx = ST_WALK;
                    ST_WALK:    state_nx = ST_FLASH;
                    default:    state_nx = ST_CLEAR;
                endcase
            end else if (state == ST_GREEN && timer == GREEN_SAT) begin
                timer_nx = timer;
            end else begin
                timer_nx = timer + 4'd1;
            end
        end
        // The request being served is consumed on walk entry; a press in
        // that very cycle is part of the same crossing.
        if (state == ST_ALL_RED && state_nx == ST_WALK) begin
            pend_nx = 1'b0;
        end else begin
            pend_nx = pend || bus.ped_req;
        end
    end

    // Head decode from the next state so the registers track the state.
    always_comb begin
        lamps_nx = lamps_for(state_nx);
        num_nx   = '0;
        if (state_nx == ST_FLASH) begin
            num_nx = CNTDN_TOP - timer_nx;
        end
    end

    assign bus.car_g    = lamps_q.car_g;
    assign bus.car_y    = lamps_q.car_y;
    assign bus.car_r    = lamps_q.car_r;
    assign bus.walk     = lamps_q.walk;
    assign bus.hand     = lamps_q.hand;
    assign bus.num_on   = lamps_q.num_on;
    assign bus.num      = num_q;
    assign bus.ped_wait = pend;
endmodule

// File: tb/tb_cwalk_ctrl.sv
// tb/tb_cwalk_ctrl.sv - self-checking bench for cwalk_ctrl
module tb_cwalk_ctrl;
    localparam logic [2:0] CG = 3'b100;
    localparam logic [2:0] CY = 3'b010;
    localparam logic [2:0] CR = 3'b001;
    localparam logic [10:0] RST_VAL = {3'b001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

    typedef struct {
        logic [2:0] car;
        logic       walk;
        logic       num_on;
        logic [3:0] num;
        logic       pw;
        int         n;
        int         req_at;
    } seg_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    seg_t sb[$];

    cwalk_ctrl_if bus ();

    cwalk_ctrl #(
        .TICK_DIV (4),
        .GREEN_MIN(8),
        .YELLOW_T (3),
        .ALLRED_T (1),
        .WALK_T   (5),
        .CNTDN_T  (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [10:0] obs = {bus.car_g, bus.car_y, bus.car_r, bus.walk, bus.hand,
                       bus.num_on, bus.num, bus.ped_wait};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [2:0] car, input logic walk, input logic num_on,
                        input logic [3:0] num, input logic pw, input int n, input int req_at);
        seg_t s;
        s.car = car; s.walk = walk; s.num_on = num_on; s.num = num;
        s.pw = pw; s.n = n; s.req_at = req_at;
        sb.push_back(s);
    endtask

    task automatic push_flash(input logic pw, input int hi, input int lo);
        for (int k = hi; k >= lo; k--) push(CR, 1'b0, 1'b1, 4'(k), pw, 4, -1);
    endtask

    // Yellow/all-red with a request pending, then an unrequested walk,
    // full countdown and clearance.
    task automatic push_service;
        push(CY, 1'b0, 1'b0, 4'd0, 1'b1, 12, -1);
        push(CR, 1'b0, 1'b0, 4'd0, 1'b1, 4, -1);
        push(CR, 1'b1, 1'b0, 4'd0, 1'b0, 20, -1);
        push_flash(1'b0, 9, 1);
        push(CR, 1'b0, 1'b0, 4'd0, 1'b0, 4, -1);
    endtask

    // Consume the scoreboard one sample per cycle; ped_req pulses are
    // launched from the segment that owns them.
    task automatic run_sb(input string tag);
        int seg_no;
        seg_t s;
        logic [10:0] e;
        seg_no = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            e = {s.car, s.walk, ~s.walk, s.num_on, s.num, s.pw};
            for (int i = 0; i < s.n; i++) begin
                @(negedge clk);
                bus.ped_req = 1'b0;
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s seg=%0d cyc=%0d observed=%b expected=%b",
                             tag, seg_no, i, obs, e);
                end
                if (i == s.req_at) bus.ped_req = 1'b1;
            end
            seg_no++;
        end
    endtask

    task automatic test_reset;
        bus.ped_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== RST_VAL) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d observed=%b expected=%b", i, obs, RST_VAL);
            end
        end
        reset = 1'b1;
        push(CR, 1'b0, 1'b0, 4'd0, 1'b0, 3, -1);
        push(CG, 1'b0, 1'b0, 4'd0, 1'b0, 1, -1);
        run_sb("reset_release");
    endtask

    // Green sample 0 was consumed by test_reset; request at green cycle 10.
    task automatic test_ped_cycle;
        push(CG, 1'b0, 1'b0, 4'd0, 1'b0, 10, 9);
        push(CG, 1'b0, 1'b0, 4'd0, 1'b1, 21, -1);
        push_service;
        run_sb("ped_cycle");
    endtask

    task automatic test_req_in_walk;
        push(CG, 1'b0, 1'b0, 4'd0, 1'b0, 1, 0);
        push(CG, 1'b0, 1'b0, 4'd0, 1'b1, 31, -1);
        push(CY, 1'b0, 1'b0, 4'd0, 1'b1, 12, -1);
        push(CR, 1'b0, 1'b0, 4'd0, 1'b1, 4, -1);
        push(CR, 1'b1, 1'b0, 4'd0, 1'b0, 6, 5);
        push(CR, 1'b1, 1'b0, 4'd0, 1'b1, 14, -1);
        push_flash(1'b1, 9, 1);
        push(CR, 1'b0, 1'b0, 4'd0, 1'b1, 4, -1);
        push(CG, 1'b0, 1'b0, 4'd0, 1'b1, 32, -1);
        push_service;
        run_sb("req_in_walk");
    endtask

    // Request first seen in the cycle whose tick brings green elapsed to 8.
    task automatic test_req_at_min;
        push(CG, 1'b0, 1'b0, 4'd0, 1'b0, 32, 31);
        push_service;
        run_sb("req_at_min");
    endtask

    // Long idle green, then a request on a tick edge (saturated timer),
    // and a second request inside the countdown.
    task automatic test_idle_then_reset;
        push(CG, 1'b0, 1'b0, 4'd0, 1'b0, 300, 299);
        push(CY, 1'b0, 1'b0, 4'd0, 1'b1, 12, -1);
        push(CR, 1'b0, 1'b0, 4'd0, 1'b1, 4, -1);
        push(CR, 1'b1, 1'b0, 4'd0, 1'b0, 20, -1);
        push(CR, 1'b0, 1'b1, 4'd9, 1'b0, 1, 0);
        push(CR, 1'b0, 1'b1, 4'd9, 1'b1, 3, -1);
        push_flash(1'b1, 8, 6);
        push(CR, 1'b0, 1'b1, 4'd5, 1'b1, 2, -1);
        run_sb("idle_to_flash");
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VAL) begin
            failures++;
            $display("FAIL async_reset observed=%b expected=%b", obs, RST_VAL);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== RST_VAL) begin
                failures++;
                $display("FAIL reset_hold2 cyc=%0d observed=%b expected=%b", i, obs, RST_VAL);
            end
        end
        reset = 1'b1;
        push(CR, 1'b0, 1'b0, 4'd0, 1'b0, 3, -1);
        push(CG, 1'b0, 1'b0, 4'd0, 1'b0, 40, -1);
        run_sb("after_reset");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.ped_req = 1'b0;
        test_reset;
        test_ped_cycle;
        test_req_in_walk;
        test_req_at_min;
        test_idle_then_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cwalk_ctrl.md
# cwalk_ctrl

Intersection sequencer for a single mid-block pedestrian crossing. It owns the vehicle signal head (green/yellow/red) and the crosswalk head (walk, hand, countdown digit). A latched pedestrian request moves the road through yellow and all-red into a walk phase, then a numbered countdown, then back to green. It sits above the crosswalk display logic and drives the same `walk`/`hand`/`num_on`/`num` signals that the display expects.

## Interface
- `TICK_DIV`, 50: clk cycles per timing tick (≥2).
- `GREEN_MIN`, 8: minimum car-green ticks before serving a request (≥1).
- `YELLOW_T`, 3: car-yellow ticks (≥1).
- `ALLRED_T`, 1: all-red clearance ticks, used before walk and after countdown (≥1).
- `WALK_T`, 5: steady-walk ticks (≥1).
- `CNTDN_T`, 9: countdown ticks (1..15).

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `ped_req`  in  1  pedestrian button, already synchronized and debounced; any high cycle is a request.
- `car_g`, `car_y`, `car_r`  out  1 each  vehicle head, exactly one high at all times.
- `walk`  out  1  walking-figure lamp.
- `hand`  out  1  don't-walk hand lamp; always equals ~`walk`.
- `num_on`  out  1  countdown digit enable.
- `num`  out  4  countdown value; 0 whenever `num_on`=0.
- `ped_wait`  out  1  "request registered" lamp, equal to the pending latch.

## Operation
- States: CLEAR → CAR_GREEN → CAR_YELLOW → ALL_RED → WALK → FLASH → CLEAR.
- Outputs are Moore and registered from the state register:
  - CAR_GREEN: car_g, hand.
  - CAR_YELLOW: car_y, hand.
  - ALL_RED and CLEAR: car_r, hand.
  - WALK: car_r, walk.
  - FLASH: car_r, hand, num_on=1.
- Reset values: state CLEAR, car_r=1, hand=1, car_g/car_y/walk/num_on/ped_wait=0, num=0, prescaler=0, tick timer=0.
- Prescaler: counts 0..TICK_DIV-1. `tick` is high when the count equals TICK_DIV-1.
- Tick timer: counts ticks elapsed in the current state and clears on every state change. In CAR_GREEN it saturates at GREEN_MIN.
- Fixed-duration states: leave on the tick that completes the state's duration (YELLOW_T, ALLRED_T, WALK_T, CNTDN_T). CLEAR uses ALLRED_T.
- CAR_GREEN exit: on a tick where elapsed ≥ GREEN_MIN (counting that tick) and (pending OR `ped_req`). With no request, green holds indefinitely.
- Pending latch:
  - Set by `ped_req` in any cycle.
  - Cleared on the edge that enters WALK. A `ped_req` in that same cycle is dropped, because it is being served.
  - A request during WALK, FLASH or CLEAR is held for the next cycle.
- FLASH countdown: `num` = CNTDN_T − elapsed ticks, so it reads CNTDN_T, CNTDN_T−1, …, 1. Widths: num is 4-bit; the tick timer is 4-bit.

## Timing
- Every state change happens on the clk edge where `tick`=1, so all states are aligned to tick boundaries.
- Each fixed state lasts exactly duration×TICK_DIV cycles.
- The first tick after reset release occurs TICK_DIV cycles later, so CLEAR after reset lasts ALLRED_T×TICK_DIV cycles.
- `ped_wait` rises one cycle after the `ped_req` cycle.
- Reset assertion mid-operation forces all reset values immediately (asynchronously). The pending request is lost.

## Structure
- Package `cwalk_pkg`:
  - state enumeration.
  - per-state output-decode constants (car/walk/hand/num_on).
- Sub-module `tick_gen`: parameterized prescaler producing the one-cycle `tick` pulse, with the same clk/reset.
- Top level holds the FSM, tick timer, pending latch and output registers.

## Test plan
All scenarios use TICK_DIV=4, GREEN_MIN=8, YELLOW_T=3, ALLRED_T=1, WALK_T=5, CNTDN_T=9.

1. Hold reset low 5 cycles → car_r=1, hand=1, all other outputs 0. Release → car_g rises exactly 4 cycles later.
2. No `ped_req` for 300 cycles after green → car_g stays 1; walk, num_on and ped_wait stay 0.
3. 1-cycle `ped_req` 10 cycles into green → ped_wait next cycle, then in sequence:
   - yellow at green cycle 32, lasting 12 cycles;
   - red 4 cycles;
   - walk 20 cycles, with ped_wait falling on walk entry;
   - num 9..1, each held 4 cycles;
   - clear 4 cycles;
   - green.
4. `ped_req` during WALK → ped_wait=1 through FLASH/CLEAR; the next green lasts exactly 32 cycles before yellow.
5. `ped_req` first asserted in the tick cycle where green elapsed reaches 8 → yellow begins on that same edge.
6. Reset asserted mid-FLASH while num=5 with a request pending → outputs equal reset values within the same cycle, ped_wait=0; after release, CLEAR then green with no walk.
